risc_v_mike_instr_mem_ctrl: RTL
===============================

Name: risc_v_mike_instr_mem_ctrl

Overview:
- Parametrised, writable instruction memory with a fetch request/response handshake, registered read and address checking.
- Sits between the fetch stage (PC side) and a program loader/debug port.
- Replaces the hard-coded combinational ROM with:
  - a RAM cleared to NOP after reset,
  - word loads at run time,
  - 1-cycle registered fetch with backpressure,
  - misaligned and out-of-range error reporting.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 1024, number of words; must be a power of two and at least 2. IDX_W = $clog2(DEPTH) is derived internally.
- ADDR_W, 32, byte address width.
- BASE_ADDR, MEM_MAP_TEXT_LOWER_LIMIT, byte address of word 0.
- INIT_WORD, 32'h00000013, value written to every word during the clear sequence (addi x0,x0,0).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address of the fetch.
- fetch_gnt  out  1  fetch accepted this cycle.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  DATA_W  fetched word.
- rsp_err  out  2  bit0 = misaligned, bit1 = out of range.
- ld_we  in  1  load-write strobe.
- ld_addr  in  ADDR_W  load byte address.
- ld_data  in  DATA_W  load word.
- ld_ack  out  1  one-cycle pulse: write performed.
- ld_err  out  1  one-cycle pulse: write rejected because of the address.
- init_done  out  1  clear sequence finished.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=CLEAR, clear counter=0.
  - Outputs: fetch_gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, ld_ack=0, ld_err=0, init_done=0.
  - Memory contents are not reset by the flops; they are rewritten by CLEAR.
- FSM states: CLEAR, RUN.
  - CLEAR: writes INIT_WORD to mem[cnt] every cycle, cnt++. When cnt==DEPTH-1 is written, go to RUN next cycle. Exactly DEPTH cycles after reset release, init_done=1, and it stays 1 until the next reset.
  - In CLEAR: fetch_gnt=0; ld_we is ignored, with no ld_ack and no ld_err.
- Address decode (same for fetch and load):
  - off = addr - BASE_ADDR, computed modulo 2^ADDR_W.
  - idx = off >> 2.
  - misaligned = (off[1:0] != 0).
  - range = (idx >= DEPTH). Addresses below BASE_ADDR wrap to a large offset and therefore flag range.
- Fetch:
  - fetch_gnt = RUN && (!rsp_valid || rsp_ready). This is combinational, with no dependence on fetch_req.
  - Accept occurs when fetch_req && fetch_gnt. On the next edge: rsp_valid=1, rsp_err={range, misaligned}, and rsp_data = mem[idx] if there is no error, else 0.
  - Latency 1 cycle. Full throughput of 1 word/cycle while rsp_ready=1.
  - rsp_valid=1 && rsp_ready=0 (stall): rsp_data and rsp_err hold stable. No new accept. Later loads to that index do not change the held rsp_data.
  - rsp_ready=1 with no new accept: rsp_valid drops to 0 next cycle and rsp_data holds its last value.
- Load:
  - ld_we in RUN with a valid address: mem[idx] = ld_data at the edge, and ld_ack=1 in the following cycle.
  - Misaligned or out-of-range address: no write, and ld_err=1 in the following cycle.
  - Back-to-back loads are allowed, one per cycle.
- Same-cycle fetch accept and load to the same idx: the fetch returns the old word (read-before-write). A later fetch returns the new word.
- Reset mid-operation: any pending response is dropped (rsp_valid=0 immediately), the FSM re-enters CLEAR, and all words are re-initialised.
- Memory is inferred as synchronous-read RAM; no combinational read path to rsp_data.

Test Plan:
- DEPTH=16. Release rst, then sample each cycle -> init_done=0 for cycles 0..15 and 1 from cycle 16; fetch_gnt=0 before that. Fetch BASE_ADDR -> rsp_data=32'h00000013, rsp_err=00, one cycle after accept.
- Load 32'h0fc10417 @BASE+0 and 32'h00100313 @BASE+4 -> ld_ack pulses on 2 consecutive cycles. Fetches of BASE+0 and BASE+4 back-to-back with rsp_ready=1 -> rsp_valid=1 for 2 cycles with those two words in order.
- Accept fetch of BASE+4, then hold rsp_ready=0 for 3 cycles while fetch_req=1 and a load rewrites BASE+4 -> fetch_gnt=0, rsp_data stays 32'h00100313. Raise rsp_ready -> next fetch is accepted the same cycle.
- Error addresses:
  - Fetch BASE+2 -> rsp_err=01, data 0.
  - Fetch BASE+64 -> rsp_err=10.
  - Fetch BASE-4 -> rsp_err=10.
  - Load to BASE+1 -> ld_err pulse, no ld_ack, memory unchanged.
- Same-cycle load 32'hDEADBEEF and fetch of BASE+8 -> response is 32'h00000013. The next fetch of BASE+8 returns 32'hDEADBEEF.
- Assert rst while rsp_valid=1 and a load is in flight -> rsp_valid=0 at once, init_done=0. After 16 cycles, a fetch of BASE+0 returns 32'h00000013.

Source files
------------

// File: rtl/risc_v_mike_instr_mem_ctrl.sv
// rtl/risc_v_mike_instr_mem_ctrl.sv - writable instruction memory with fetch handshake
//
// Purpose: instruction RAM between the fetch stage and a program loader.
// After reset, a clear sequence writes INIT_WORD to every word, one word
// per cycle. After that, the memory serves fetches with a 1-cycle
// registered read and backpressure, and it accepts word loads. Both
// paths report misaligned and out-of-range addresses.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   fetch_req/addr/gnt       fetch request, byte address, accept (combinational)
//   rsp_valid/ready/data/err response handshake, word, {range, misaligned}
//   ld_we/addr/data          loader write strobe, byte address, word
//   ld_ack, ld_err           one-cycle pulses: write done / write rejected
//   init_done                clear sequence finished
module risc_v_mike_instr_mem_ctrl #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       ADDR_W    = 32,
  // Lower limit of the text segment in the memory map.
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0001_0000),
  parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_err,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  output logic              ld_err,
  output logic              init_done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [1:0]         rsp_err_q, rsp_err_d;
  logic               data_ok_q, data_ok_d;
  logic               ld_ack_q, ld_err_q;
  logic [DATA_W-1:0]  rd_data_q;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Address decode. Subtraction wraps, so addresses below BASE_ADDR
  // become large offsets and fall into the out-of-range check.
  logic [ADDR_W-1:0]  f_off, l_off;
  logic [IDX_W-1:0]   f_idx, l_idx;
  logic               f_mis, f_rng, l_mis, l_rng;

  assign f_off = fetch_addr - BASE_ADDR;
  assign l_off = ld_addr - BASE_ADDR;
  assign f_idx = f_off[IDX_W+1:2];
  assign l_idx = l_off[IDX_W+1:2];
  assign f_mis = |f_off[1:0];
  assign l_mis = |l_off[1:0];
  assign f_rng = |f_off[ADDR_W-1:IDX_W+2];
  assign l_rng = |l_off[ADDR_W-1:IDX_W+2];

  logic run, accept, ld_fire, ld_ok;

  assign run       = (state_q == ST_RUN);
  assign fetch_gnt = run && (!rsp_valid_q || rsp_ready);
  assign accept    = fetch_req && fetch_gnt;
  assign ld_fire   = run && ld_we;
  assign ld_ok     = ld_fire && !(l_mis || l_rng);

  // Single write port shared by the clear sequence and the loader.
  logic               mem_we;
  logic [IDX_W-1:0]   mem_widx;
  logic [DATA_W-1:0]  mem_wdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_widx  = l_idx;
    mem_wdata = ld_data;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = cnt_q;
        mem_wdata = INIT_WORD;
        cnt_d     = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN:  mem_we = ld_ok;
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    data_ok_d   = data_ok_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = {f_rng, f_mis};
      data_ok_d   = !(f_rng || f_mis);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 2'b00;
      data_ok_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      ld_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      data_ok_q   <= data_ok_d;
      ld_ack_q    <= ld_ok;
      ld_err_q    <= ld_fire && !ld_ok;
    end
  end

  // RAM array with a synchronous read. The read samples the old word when a
  // load hits the same index in the same cycle (read-before-write). The read
  // register loads only on accept, so the data held during a stall does not
  // change when later loads rewrite that index.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
    if (accept) rd_data_q <= mem[f_idx];
  end

  // Error responses and the reset state show zero. data_ok_q does this
  // without putting a reset on the RAM read register.
  assign rsp_data  = data_ok_q ? rd_data_q : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign ld_ack    = ld_ack_q;
  assign ld_err    = ld_err_q;
  assign init_done = run;

endmodule
